// File: rtl/bit_stuffer_if.sv
// rtl/bit_stuffer_if.sv - serial bit stream bundle between encoder, stuffer and NRZI encoder
interface bit_stuffer_if;
  logic s_in;
  logic in_valid;
  logic in_ready;
  logic start_stuffer;
  logic end_stuffer;
  logic s_out;
  logic out_valid;
  logic start_nrzi;
  logic end_nrzi;
  logic underrun;

  modport slave (
    input  s_in, in_valid, start_stuffer, end_stuffer,
    output in_ready, s_out, out_valid, start_nrzi, end_nrzi, underrun
  );

  modport master (
    output s_in, in_valid, start_stuffer, end_stuffer,
    input  in_ready, s_out, out_valid, start_nrzi, end_nrzi, underrun
  );
endinterface

// File: rtl/bit_stuffer.sv
// rtl/bit_stuffer.sv - USB TX bit stuffer: inserts a 0 after every RUN_LEN consecutive 1s
module bit_stuffer #(
  parameter int RUN_LEN = 6,
  parameter int CNT_W   = 3
) (
  input  logic         clk,
  input  logic         rst,
  bit_stuffer_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, STUFF = 2'd2} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   ones, ones_upd, ones_nxt;
  logic               pend_end, pend_end_nxt;
  logic               s_out_nxt, out_valid_nxt, start_nrzi_nxt, end_nrzi_nxt, underrun_nxt;
  logic               run_done;

  assign ones_upd = bus.s_in ? ones + CNT_W'(1) : '0;
  assign run_done = (ones_upd == CNT_W'(RUN_LEN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      ones           <= '0;
      pend_end       <= 1'b0;
      bus.s_out      <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.start_nrzi <= 1'b0;
      bus.end_nrzi   <= 1'b0;
      bus.underrun   <= 1'b0;
    end else begin
      state          <= state_nxt;
      ones           <= ones_nxt;
      pend_end       <= pend_end_nxt;
      bus.s_out      <= s_out_nxt;
      bus.out_valid  <= out_valid_nxt;
      bus.start_nrzi <= start_nrzi_nxt;
      bus.end_nrzi   <= end_nrzi_nxt;
      bus.underrun   <= underrun_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ones_nxt     = ones;
    pend_end_nxt = pend_end;
    case (state)
      IDLE: begin
        if (bus.in_valid && bus.start_stuffer) begin
          ones_nxt = ones_upd;
          if (run_done) begin
            state_nxt    = STUFF;
            pend_end_nxt = bus.end_stuffer;
          end else if (bus.end_stuffer) begin
            ones_nxt = '0;
          end else begin
            state_nxt = SEND;
          end
        end
      end
      SEND: begin
        if (bus.in_valid) begin
          ones_nxt = ones_upd;
          if (run_done) begin
            state_nxt    = STUFF;
            pend_end_nxt = bus.end_stuffer;
          end else if (bus.end_stuffer) begin
            state_nxt = IDLE;
            ones_nxt  = '0;
          end
        end
      end
      STUFF: begin
        ones_nxt     = '0;
        pend_end_nxt = 1'b0;
        state_nxt    = pend_end ? IDLE : SEND;
      end
      default: begin
        state_nxt    = IDLE;
        ones_nxt     = '0;
        pend_end_nxt = 1'b0;
      end
    endcase
  end

  // Output values for the next cycle; the encoder stalls only while the stuffed 0 goes out.
  always_comb begin
    bus.in_ready   = (state != STUFF);
    s_out_nxt      = 1'b0;
    out_valid_nxt  = 1'b0;
    start_nrzi_nxt = 1'b0;
    end_nrzi_nxt   = 1'b0;
    underrun_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid && bus.start_stuffer) begin
          s_out_nxt      = bus.s_in;
          out_valid_nxt  = 1'b1;
          start_nrzi_nxt = 1'b1;
          end_nrzi_nxt   = bus.end_stuffer && !run_done;
        end
      end
      SEND: begin
        if (bus.in_valid) begin
          s_out_nxt     = bus.s_in;
          out_valid_nxt = 1'b1;
          end_nrzi_nxt  = bus.end_stuffer && !run_done;
        end else begin
          underrun_nxt = 1'b1;
        end
      end
      STUFF: begin
        out_valid_nxt = 1'b1;
        end_nrzi_nxt  = pend_end;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bit_stuffer.sv
// tb/tb_bit_stuffer.sv - directed bench for bit_stuffer
module tb_bit_stuffer;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  bit_stuffer_if bus ();

  bit_stuffer #(.RUN_LEN(6), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // e = {in_ready before edge, out_valid, s_out, start_nrzi, end_nrzi, underrun after edge}
  task automatic cyc(input string tag, input logic v, input logic s, input logic st,
                     input logic en, input logic [5:0] e);
    bus.in_valid      = v;
    bus.s_in          = s;
    bus.start_stuffer = st;
    bus.end_stuffer   = en;
    #1;
    chk({tag, ".in_ready"}, bus.in_ready, e[5]);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".out_valid"},  bus.out_valid,  e[4]);
    chk({tag, ".s_out"},      bus.s_out,      e[3]);
    chk({tag, ".start_nrzi"}, bus.start_nrzi, e[2]);
    chk({tag, ".end_nrzi"},   bus.end_nrzi,   e[1]);
    chk({tag, ".underrun"},   bus.underrun,   e[0]);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.in_valid      = 1'b0;
    bus.s_in          = 1'b0;
    bus.start_stuffer = 1'b0;
    bus.end_stuffer   = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst.in_ready",  bus.in_ready,   1'b1);
    chk("rst.out_valid", bus.out_valid,  1'b0);
    chk("rst.s_out",     bus.s_out,      1'b0);
    chk("rst.start",     bus.start_nrzi, 1'b0);
    chk("rst.end",       bus.end_nrzi,   1'b0);
    chk("rst.underrun",  bus.underrun,   1'b0);
    rst = 1'b0;

    // 1: seven 1s then 0 with end
    cyc("t1.b1", 1, 1, 1, 0, 6'b111100);
    for (int i = 0; i < 5; i++) cyc("t1.ones", 1, 1, 0, 0, 6'b111000);
    cyc("t1.stuff", 1, 1, 0, 0, 6'b010000);
    cyc("t1.b7",    1, 1, 0, 0, 6'b111000);
    cyc("t1.last",  1, 0, 0, 1, 6'b110010);
    cyc("t1.idle",  0, 0, 0, 0, 6'b100000);

    // 2: twelve 1s, end lands on trailing stuffed 0
    cyc("t2.b1", 1, 1, 1, 0, 6'b111100);
    for (int i = 0; i < 5; i++) cyc("t2.ones_a", 1, 1, 0, 0, 6'b111000);
    cyc("t2.stuff1", 1, 1, 0, 0, 6'b010000);
    for (int i = 0; i < 5; i++) cyc("t2.ones_b", 1, 1, 0, 0, 6'b111000);
    cyc("t2.b12",    1, 1, 0, 1, 6'b111000);
    cyc("t2.stuff2", 1, 1, 0, 1, 6'b010010);
    cyc("t2.idle",   0, 0, 0, 0, 6'b100000);

    // 3: 1x5, 0, 1x5 - no stuffing
    cyc("t3.b1", 1, 1, 1, 0, 6'b111100);
    for (int i = 0; i < 4; i++) cyc("t3.ones_a", 1, 1, 0, 0, 6'b111000);
    cyc("t3.zero", 1, 0, 0, 0, 6'b110000);
    for (int i = 0; i < 4; i++) cyc("t3.ones_b", 1, 1, 0, 0, 6'b111000);
    cyc("t3.last", 1, 1, 0, 1, 6'b111010);
    cyc("t3.idle", 0, 0, 0, 0, 6'b100000);

    // 4: one-bit packet, then a stray bit in IDLE is discarded
    cyc("t4.one",     1, 0, 1, 1, 6'b110110);
    cyc("t4.discard", 1, 1, 0, 0, 6'b100000);

    // 5: reset while in STUFF
    cyc("t5.b1", 1, 1, 1, 0, 6'b111100);
    for (int i = 0; i < 5; i++) cyc("t5.ones", 1, 1, 0, 0, 6'b111000);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5.rst.in_ready",  bus.in_ready,  1'b1);
    chk("t5.rst.out_valid", bus.out_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("t5.edge.in_ready",  bus.in_ready,  1'b1);
    chk("t5.edge.out_valid", bus.out_valid, 1'b0);
    chk("t5.edge.end_nrzi",  bus.end_nrzi,  1'b0);
    rst = 1'b0;
    cyc("t5.p2.b1", 1, 1, 1, 0, 6'b111100);
    for (int i = 0; i < 5; i++) cyc("t5.p2.ones", 1, 1, 0, 0, 6'b111000);
    cyc("t5.p2.stuff", 0, 0, 0, 0, 6'b010000);
    cyc("t5.p2.last",  1, 0, 0, 1, 6'b110010);
    cyc("t5.p2.idle",  0, 0, 0, 0, 6'b100000);

    // 6: underrun mid-packet holds the ones count
    cyc("t6.b1", 1, 1, 1, 0, 6'b111100);
    for (int i = 0; i < 2; i++) cyc("t6.ones_a", 1, 1, 0, 0, 6'b111000);
    for (int i = 0; i < 2; i++) cyc("t6.gap",    0, 0, 0, 0, 6'b100001);
    for (int i = 0; i < 3; i++) cyc("t6.ones_b", 1, 1, 0, 0, 6'b111000);
    cyc("t6.stuff", 1, 0, 0, 1, 6'b010000);
    cyc("t6.last",  1, 0, 0, 1, 6'b110010);
    cyc("t6.idle",  0, 0, 0, 0, 6'b100000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
